// File: rtl/fault_injector_seq.sv
// fault_injector_seq: scheduled, parametrised fault-injection stage on a
// WIDTH-bit data path. An accepted descriptor arms the block; after
// cfg_delay cycles it corrupts the masked bits of cfg_dur samples
// (0 = until abort) using one of four modes. Outside that window the
// data path is a transparent one-cycle register.
//
// Optional feature: define FI_COUNT_EN to add inj_count_o, a saturating
// count of completed (non-aborted) injections.
//
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   data_i / data_o        data under test / registered, possibly corrupted copy
//   cfg_valid / cfg_ready  descriptor handshake (cfg_ready combinational)
//   cfg_mask, cfg_mode     target bits, fault mode (00 SA0, 01 SA1, 10 flip, 11 alt flip)
//   cfg_delay, cfg_dur     cycles to first corrupted sample, number of corrupted samples
//   abort_i                cancel any scheduled or active fault
//   active_o, done_o       in ACTIVE / one-cycle completion pulse
//   inj_count_o            completed-injection count (FI_COUNT_EN only)
module fault_injector_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DLY_W = 16,
    parameter int unsigned DUR_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [1:0]       cfg_mode,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [DUR_W-1:0] cfg_dur,
    input  logic             abort_i,
    output logic             active_o,
    output logic             done_o
`ifdef FI_COUNT_EN
    ,
    output logic [CNT_W-1:0] inj_count_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] MODE_SA0  = 2'b00;
    localparam logic [1:0] MODE_SA1  = 2'b01;
    localparam logic [1:0] MODE_FLIP = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [1:0]       mode_q, mode_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [DUR_W-1:0] len_q, len_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             alt_q, alt_d;
    logic             corrupt;
    logic             done_d;
    logic [WIDTH-1:0] data_f;

    assign cfg_ready = (state_q == ST_IDLE) && !abort_i;

    // State and latched descriptor registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            mode_q  <= '0;
            dly_q   <= '0;
            len_q   <= '0;
            dur_q   <= '0;
            alt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            dly_q   <= dly_d;
            len_q   <= len_d;
            dur_q   <= dur_d;
            alt_q   <= alt_d;
        end
    end

    // Next-state logic; corrupt marks an edge that registers a faulted sample
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
        dly_d   = dly_q;
        len_d   = len_q;
        dur_d   = dur_q;
        alt_d   = alt_q;
        corrupt = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    state_d = ST_ARMED;
                    mask_d  = cfg_mask;
                    mode_d  = cfg_mode;
                    dly_d   = cfg_delay;
                    len_d   = cfg_dur;
                    dur_d   = '0;
                    alt_d   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (dly_q == '0) begin
                    // The transition edge itself carries the first corrupted sample
                    state_d = ST_ACTIVE;
                    corrupt = 1'b1;
                    alt_d   = ~alt_q;
                    if (len_q != '0) begin
                        dur_d = DUR_W'(1);
                    end
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_ACTIVE: begin
                if ((len_q != '0) && (dur_q == len_q)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    corrupt = 1'b1;
                    alt_d   = ~alt_q;
                    // Permanent faults never advance the counter, so it cannot wrap
                    if (len_q != '0) begin
                        dur_d = dur_q + DUR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = '0;
                mode_d  = '0;
                len_d   = '0;
                dur_d   = '0;
                alt_d   = 1'b0;
            end
        endcase

        // Abort overrides everything, including a same-cycle acceptance
        if (abort_i) begin
            state_d = ST_IDLE;
            corrupt = 1'b0;
            done_d  = 1'b0;
            mask_d  = '0;
            mode_d  = '0;
            dly_d   = '0;
            len_d   = '0;
            dur_d   = '0;
            alt_d   = 1'b0;
        end
    end

    // Fault function; alt_q low means the next alternating sample is flipped
    always_comb begin
        data_f = data_i;
        if (corrupt) begin
            case (mode_q)
                MODE_SA0:  data_f = data_i & ~mask_q;
                MODE_SA1:  data_f = data_i | mask_q;
                MODE_FLIP: data_f = data_i ^ mask_q;
                default:   data_f = alt_q ? data_i : (data_i ^ mask_q);
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_o   <= '0;
            active_o <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            data_o   <= data_f;
            active_o <= (state_d == ST_ACTIVE);
            done_o   <= done_d;
        end
    end

`ifdef FI_COUNT_EN
    // Saturating count of completed injections
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inj_count_o <= '0;
        end else if (done_d && (inj_count_o != {CNT_W{1'b1}})) begin
            inj_count_o <= inj_count_o + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_fault_injector_seq.sv
// Directed, table-driven bench for fault_injector_seq (WIDTH=8).
// Each vector is driven on the falling edge; outputs are checked 1 time
// unit after the following rising edge with the vector's inputs still held.
module tb_fault_injector_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  data_i;
    logic [7:0]  data_o;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_mask;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_dur;
    logic        abort_i;
    logic        active_o;
    logic        done_o;
`ifdef FI_COUNT_EN
    logic [1:0]  inj_count_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fault_injector_seq #(
        .WIDTH(8), .DLY_W(16), .DUR_W(16), .CNT_W(2)
    ) dut (
        .clk(clk), .rstn(rstn),
        .data_i(data_i), .data_o(data_o),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
        .cfg_delay(cfg_delay), .cfg_dur(cfg_dur),
        .abort_i(abort_i), .active_o(active_o), .done_o(done_o)
`ifdef FI_COUNT_EN
        , .inj_count_o(inj_count_o)
`endif
    );

    typedef struct {
        logic        rstn;
        logic [7:0]  din;
        logic        valid;
        logic [7:0]  mask;
        logic [1:0]  mode;
        logic [15:0] dly;
        logic [15:0] dur;
        logic        abort;
        logic [7:0]  e_data;
        logic        e_ready;
        logic        e_active;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [7:0] din, input logic v,
                                input logic [7:0] m, input logic [1:0] md,
                                input logic [15:0] d, input logic [15:0] l, input logic a,
                                input logic [7:0] ed, input logic erdy,
                                input logic eact, input logic edone);
        vec_t t;
        t.rstn = r;   t.din = din;  t.valid = v;   t.mask = m;
        t.mode = md;  t.dly = d;    t.dur = l;     t.abort = a;
        t.e_data = ed; t.e_ready = erdy; t.e_active = eact; t.e_done = edone;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rstn = v.rstn; data_i = v.din; cfg_valid = v.valid; cfg_mask = v.mask;
        cfg_mode = v.mode; cfg_delay = v.dly; cfg_dur = v.dur; abort_i = v.abort;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input vec_t v, input string tag);
        drive(v);
        chk({tag, ".data_o"},   32'(data_o),    32'(v.e_data));
        chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(v.e_ready));
        chk({tag, ".active_o"}, 32'(active_o),  32'(v.e_active));
        chk({tag, ".done_o"},   32'(done_o),    32'(v.e_done));
    endtask

    initial begin
        rstn = 1'b0; data_i = 8'h00; cfg_valid = 1'b0; cfg_mask = 8'h00;
        cfg_mode = 2'b00; cfg_delay = 16'd0; cfg_dur = 16'd0; abort_i = 1'b0;

        //             rstn din    v  mask  mode   D  L  ab   data  rdy act done
        // Reset held 3 edges, then release
        vecs.push_back(mk(0, 8'hA5, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'hA5, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'hA5, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(1, 8'hA5, 0, 8'h00, 2'b00, 0, 0, 0, 8'hA5, 1, 0, 0));
        // SA1, D=2, L=3: corrupted after T+3..T+5, DONE after T+6
        vecs.push_back(mk(1, 8'h00, 1, 8'h01, 2'b01, 2, 3, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h01, 0, 1, 0));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h01, 0, 1, 0));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h01, 0, 1, 0));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 1, 0, 0));
        // ALT, D=0, L=4, with a different descriptor held valid while busy
        vecs.push_back(mk(1, 8'hF0, 1, 8'hFF, 2'b11, 0, 4, 0, 8'hF0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 1, 8'h33, 2'b01, 0, 1, 0, 8'h0F, 0, 1, 0));
        vecs.push_back(mk(1, 8'hF0, 1, 8'h33, 2'b01, 0, 1, 0, 8'hF0, 0, 1, 0));
        vecs.push_back(mk(1, 8'hF0, 1, 8'h33, 2'b01, 0, 1, 0, 8'h0F, 0, 1, 0));
        vecs.push_back(mk(1, 8'hF0, 1, 8'h33, 2'b01, 0, 1, 0, 8'hF0, 0, 1, 0));
        vecs.push_back(mk(1, 8'hF0, 1, 8'h33, 2'b01, 0, 1, 0, 8'hF0, 0, 0, 1));
        vecs.push_back(mk(1, 8'hF0, 1, 8'h33, 2'b01, 0, 1, 0, 8'hF0, 1, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 8'h00, 2'b00, 0, 0, 0, 8'hF0, 1, 0, 0));
        // mask=0, D=0, L=1: data unchanged, done still pulses
        vecs.push_back(mk(1, 8'h5A, 1, 8'h00, 2'b10, 0, 1, 0, 8'h5A, 0, 0, 0));
        vecs.push_back(mk(1, 8'h5A, 0, 8'h00, 2'b00, 0, 0, 0, 8'h5A, 0, 1, 0));
        vecs.push_back(mk(1, 8'h5A, 0, 8'h00, 2'b00, 0, 0, 0, 8'h5A, 0, 0, 1));
        vecs.push_back(mk(1, 8'h5A, 0, 8'h00, 2'b00, 0, 0, 0, 8'h5A, 1, 0, 0));
        // abort together with cfg_valid in IDLE: no acceptance
        vecs.push_back(mk(1, 8'h3C, 1, 8'hFF, 2'b10, 0, 1, 1, 8'h3C, 0, 0, 0));
        vecs.push_back(mk(1, 8'h3C, 0, 8'h00, 2'b00, 0, 0, 0, 8'h3C, 1, 0, 0));
        // abort during ARMED: fault never fires
        vecs.push_back(mk(1, 8'h00, 1, 8'hFF, 2'b10, 3, 2, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 1, 8'h00, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 1, 0, 0));
        // reset mid-injection: fault dropped, no done
        vecs.push_back(mk(1, 8'hAA, 1, 8'hFF, 2'b10, 0, 5, 0, 8'hAA, 0, 0, 0));
        vecs.push_back(mk(1, 8'hAA, 0, 8'h00, 2'b00, 0, 0, 0, 8'h55, 0, 1, 0));
        vecs.push_back(mk(0, 8'hAA, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 1, 0, 0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(1, 8'hAA, 0, 8'h00, 2'b00, 0, 0, 0, 8'hAA, 1, 0, 0));

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Permanent SA0, D=1, L=0, aborted at T+10
        step(mk(1, 8'hFF, 1, 8'h0F, 2'b00, 1, 0, 0, 8'hFF, 0, 0, 0), "perm.T");
        step(mk(1, 8'hFF, 0, 8'h00, 2'b00, 0, 0, 0, 8'hFF, 0, 0, 0), "perm.T1");
        for (int k = 2; k < 10; k++)
            step(mk(1, 8'hFF, 0, 8'h00, 2'b00, 0, 0, 0, 8'hF0, 0, 1, 0),
                 $sformatf("perm.T%0d", k));
        step(mk(1, 8'hFF, 0, 8'h00, 2'b00, 0, 0, 1, 8'hFF, 0, 0, 0), "perm.abort");
        step(mk(1, 8'hFF, 0, 8'h00, 2'b00, 0, 0, 0, 8'hFF, 1, 0, 0), "perm.after");
        step(mk(1, 8'hFF, 0, 8'h00, 2'b00, 0, 0, 0, 8'hFF, 1, 0, 0), "perm.idle");

`ifdef FI_COUNT_EN
        // Saturating count: five completions, one abort, CNT_W=2
        drive(mk(0, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0, 0, 0));
        chk("count.reset", 32'(inj_count_o), 32'd0);
        for (int n = 1; n <= 5; n++) begin
            drive(mk(1, 8'h00, 1, 8'h00, 2'b00, 0, 1, 0, 8'h00, 0, 0, 0));
            for (int c = 0; c < 3; c++)
                drive(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0, 0, 0));
            chk($sformatf("count.n%0d", n), 32'(inj_count_o), (n > 3) ? 32'd3 : 32'(n));
        end
        drive(mk(1, 8'h00, 1, 8'h00, 2'b00, 0, 1, 0, 8'h00, 0, 0, 0));
        drive(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 1, 8'h00, 0, 0, 0));
        drive(mk(1, 8'h00, 0, 8'h00, 2'b00, 0, 0, 0, 8'h00, 0, 0, 0));
        chk("count.aborted", 32'(inj_count_o), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fault_injector_seq.md
Name: fault_injector_seq

Overview:
- Parametrised, scheduled fault-injection stage. Successor to the fixed-pin injection module; sits inline on a WIDTH-bit data path under validation.
- Passes data_i to a registered data_o.
- Once a fault descriptor is accepted, waits a programmable delay, then corrupts the masked bits for a programmable duration using one of four fault modes. It then returns to transparent pass-through.

Parameters:
- WIDTH, 8: data path width in bits.
- DLY_W, 16: width of the delay field.
- DUR_W, 16: width of the duration field.
- CNT_W, 8: width of the injection counter (used only with FI_COUNT_EN).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- data_i  in  WIDTH  data under test.
- data_o  out  WIDTH  registered, possibly corrupted, copy of data_i.
- cfg_valid  in  1  fault descriptor valid.
- cfg_ready  out  1  block can accept a descriptor.
- cfg_mask  in  WIDTH  bits to corrupt; 1 = target.
- cfg_mode  in  2  fault mode: 00 stuck-at-0, 01 stuck-at-1, 10 bit-flip, 11 alternating flip.
- cfg_delay  in  DLY_W  cycles from acceptance to first corrupted sample.
- cfg_dur  in  DUR_W  number of corrupted samples; 0 = permanent.
- abort_i  in  1  cancel any scheduled or active fault.
- active_o  out  1  high while in ACTIVE.
- done_o  out  1  one-cycle pulse when a non-aborted injection completes.

Behaviour:
- Reset (rstn low at an edge):
  - state=IDLE, data_o=0, done_o=0, active_o=0.
  - Internal mask, mode and counters cleared.
  - cfg_ready=1 from the first cycle after reset.
  - Reset mid-operation drops any fault immediately; no done_o.
- Data path:
  - data_o <= f(data_i) every edge; latency 1 cycle.
  - f is identity outside ACTIVE.
  - Inside ACTIVE, per latched mode: SA0 data_i & ~mask; SA1 data_i | mask; FLIP data_i ^ mask.
  - ALT flips on the 1st, 3rd, 5th ... corrupted sample and passes on the 2nd, 4th, ...
- cfg_ready = (state==IDLE) && !abort_i; combinational.
- Acceptance: cfg_valid && cfg_ready at edge T.
  - mask, mode, delay D and duration L are latched at T.
  - Inputs in later cycles have no effect until the block is back in IDLE.
- FSM:
  - IDLE -> ARMED on accept; delay counter loaded with D.
  - ARMED: counter decrements each edge. When counter==0 at an edge, go to ACTIVE; that same edge produces the first corrupted sample.
  - With D=0, the first corrupted sample is registered at edge T+1.
  - General case: corrupted samples are registered at edges T+D+1 .. T+D+L.
  - ACTIVE: duration counter counts corrupted samples. After the L-th, go to DONE.
  - ACTIVE with L=0: stays ACTIVE (permanent) until abort_i or reset.
  - DONE: lasts one cycle with done_o=1 and data_o transparent, then IDLE. cfg_ready is 0 during DONE.
- abort_i high at an edge, in any state:
  - Next state is IDLE.
  - Sample at that edge is NOT corrupted.
  - No done_o.
  - Latched config is discarded.
- abort_i together with cfg_valid in IDLE: abort wins; no acceptance.
- cfg_mask=0: timing runs normally, data unchanged, done_o still pulses.
- Counters do not wrap: D and L up to 2^DLY_W-1 and 2^DUR_W-1 are honoured exactly.
- active_o = (state==ACTIVE); registered with state.

Optional Feature:
- Macro: FI_COUNT_EN.
- Defined:
  - Adds output inj_count_o [CNT_W-1:0].
  - Increments on each done_o pulse and saturates at 2^CNT_W-1.
  - Cleared only by reset; aborted or permanent injections are not counted.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold rstn=0 for 3 edges with data_i=0xA5 -> data_o=0x00, cfg_ready=1 after release, data_o=0xA5 one edge after release.
- SA1 timed: data_i=0x00, accept mask=0x01, mode=01, D=2, L=3 at edge T -> data_o=0x01 after edges T+3..T+5; 0x00 after T+6; done_o=1 in the cycle after T+6; cfg_ready=1 the cycle after.
- ALT flip: data_i=0xF0, mask=0xFF, mode=11, D=0, L=4 -> data_o sequence after edges T+1..T+4 = 0x0F, 0xF0, 0x0F, 0xF0; then 0xF0; done_o pulses once.
- Permanent + abort: mode=00, mask=0x0F, D=1, L=0, data_i=0xFF -> data_o=0xF0 from edge T+2 onward; abort_i at edge T+10 -> data_o=0xFF after T+10; no done_o; cfg_ready=1 the cycle after T+10.
- Busy and simultaneous events: cfg_valid held high during ARMED/ACTIVE -> no second acceptance. abort_i and cfg_valid together in IDLE -> no acceptance, state stays IDLE.
- FI_COUNT_EN with CNT_W=2: five completed injections plus one aborted -> inj_count_o=3 (saturated).
